// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - two-digit hex seven-segment scan driver with one-deep pending buffer
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN (suppress a zero high digit).
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 1024,
    parameter int DEAD_CYC    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    input  logic       blank,
    output logic [6:0] seg,
    output logic       digit_sel,
    output logic [7:0] shown
);

    localparam int MAX_CYC = (REFRESH_DIV > DEAD_CYC) ? REFRESH_DIV : DEAD_CYC;
    localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYC - 1);

    typedef enum logic [1:0] {
        SHOW_LO = 2'd0,
        DEAD_LO = 2'd1,
        SHOW_HI = 2'd2,
        DEAD_HI = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       shown_q;
    logic [7:0]       pend;
    logic             pend_full;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SHOW_LO;
            cnt       <= SHOW_LOAD;
            shown_q   <= 8'h00;
            pend      <= 8'h00;
            pend_full <= 1'b0;
        end else begin
            if (data_valid && !pend_full) begin
                pend      <= data_in;
                pend_full <= 1'b1;
            end
            if (cnt == '0) begin
                case (state)
                    SHOW_LO: begin
                        state <= DEAD_LO;
                        cnt   <= DEAD_LOAD;
                    end
                    DEAD_LO: begin
                        state <= SHOW_HI;
                        cnt   <= SHOW_LOAD;
                    end
                    SHOW_HI: begin
                        state <= DEAD_HI;
                        cnt   <= DEAD_LOAD;
                    end
                    default: begin
                        state <= SHOW_LO;
                        cnt   <= SHOW_LOAD;
                        // Frame boundary: the only point where the shown byte may change.
                        if (pend_full) begin
                            shown_q   <= pend;
                            pend_full <= 1'b0;
                        end
                    end
                endcase
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        seg = 7'h00;
        if (!blank) begin
            case (state)
                SHOW_LO: seg = glyph(shown_q[3:0]);
                SHOW_HI: begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
                    seg = (shown_q[7:4] == 4'h0) ? 7'h00 : glyph(shown_q[7:4]);
`else
                    seg = glyph(shown_q[7:4]);
`endif
                end
                default: seg = 7'h00;
            endcase
        end
    end

    assign digit_sel  = (state == SHOW_HI) || (state == DEAD_HI);
    assign data_ready = !pend_full;
    assign shown      = shown_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed table-driven bench for seg7_scan_driver (REFRESH_DIV=8, DEAD_CYC=2)
module tb_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       blank = 1'b0;
    logic [6:0] seg;
    logic       digit_sel;
    logic [7:0] shown;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    seg7_scan_driver #(.REFRESH_DIV(8), .DEAD_CYC(2)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .blank(blank), .seg(seg),
        .digit_sel(digit_sel), .shown(shown)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] val;
        logic [6:0] lo;
        logic [6:0] hi;
    } vec_t;

    vec_t vecs [8];
    int   checks = 0;
    int   errors = 0;
    int   phase  = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (phase %0d)", name, act, exp, phase);
        end
    endtask

    // Phase 0..7 SHOW_LO, 8..9 DEAD_LO, 10..17 SHOW_HI, 18..19 DEAD_HI.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        phase = (phase + 1) % 20;
    endtask

    task automatic sync_phase(input int target);
        for (int i = 0; i < 20 && phase != target; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        phase = 0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!data_ready && n < 50) begin
            step();
            n++;
        end
        if (!data_ready) chk("ready_timeout", 8'(data_ready), 8'h01);
    endtask

    function automatic logic [6:0] exp_seg(input int ph, input logic [6:0] lo, input logic [6:0] hi);
        if (ph < 8) return lo;
        if (ph >= 10 && ph < 18) return hi;
        return 7'h00;
    endfunction

    task automatic frame_check(input string name, input logic [6:0] lo, input logic [6:0] hi);
        for (int i = 0; i < 20; i++) begin
            chk({name, "_seg"}, 8'(seg), 8'(exp_seg(phase, lo, hi)));
            chk({name, "_dsel"}, 8'(digit_sel), 8'(phase >= 10));
            step();
        end
    endtask

    logic [6:0] hi_zero;
    logic [6:0] hi_exp;

    initial begin
        hi_zero = LZ ? 7'h00 : 7'h3F;
        vecs[0] = '{8'hA5, 7'h6D, 7'h77};
        vecs[1] = '{8'h3C, 7'h39, 7'h4F};
        vecs[2] = '{8'h07, 7'h07, 7'h3F};
        vecs[3] = '{8'h8E, 7'h79, 7'h7F};
        vecs[4] = '{8'hBD, 7'h5E, 7'h7C};
        vecs[5] = '{8'h69, 7'h6F, 7'h7D};
        vecs[6] = '{8'h04, 7'h66, 7'h3F};
        vecs[7] = '{8'hFF, 7'h71, 7'h71};

        do_reset();
        chk("rst_seg", 8'(seg), 8'h3F);
        chk("rst_dsel", 8'(digit_sel), 8'h00);
        chk("rst_ready", 8'(data_ready), 8'h01);
        chk("rst_shown", shown, 8'h00);
        frame_check("rst_frame", 7'h3F, hi_zero);

        // Backpressure: 0x12 held, 0x34 and 0x56 offered while full.
        data_in = 8'h12; data_valid = 1'b1;
        step();
        chk("bp_ready_low", 8'(data_ready), 8'h00);
        data_in = 8'h34;
        for (int i = 0; i < 9; i++) step();
        data_in = 8'h56;
        begin
            int n;
            n = 0;
            while (!data_ready && n < 50) begin
                chk("bp_no34", 8'(shown == 8'h34), 8'h00);
                step();
                n++;
            end
        end
        chk("bp_ready_phase", 8'(phase), 8'h00);
        chk("bp_shown12", shown, 8'h12);
        step();
        data_valid = 1'b0;
        chk("bp_ready_low2", 8'(data_ready), 8'h00);
        for (int i = 0; i < 19; i++) begin
            chk("bp_hold12", shown, 8'h12);
            if (phase == 12) chk("bp_hi_seg", 8'(seg), 8'h06);
            step();
        end
        chk("bp_shown56", shown, 8'h56);

        // Main table: each value appears at the next boundary and scans correctly.
        for (int v = 0; v < 8; v++) begin
            wait_ready();
            if (phase == 19) step();
            data_in = vecs[v].val; data_valid = 1'b1;
            step();
            data_valid = 1'b0;
            chk("vec_ready_low", 8'(data_ready), 8'h00);
            sync_phase(0);
            chk("vec_shown", shown, vecs[v].val);
            chk("vec_ready_back", 8'(data_ready), 8'h01);
            hi_exp = (LZ && vecs[v].val[7:4] == 4'h0) ? 7'h00 : vecs[v].hi;
            frame_check($sformatf("vec%0h", vecs[v].val), vecs[v].lo, hi_exp);
        end

        // Blank during SHOW_HI with 0xFF shown; scan timing must not move.
        sync_phase(12);
        blank = 1'b1;
        #1;
        chk("blank_seg", 8'(seg), 8'h00);
        chk("blank_dsel", 8'(digit_sel), 8'h01);
        step();
        blank = 1'b0;
        #1;
        chk("unblank_seg", 8'(seg), 8'h71);
        sync_phase(18);
        chk("blank_dead_seg", 8'(seg), 8'h00);
        chk("blank_dead_dsel", 8'(digit_sel), 8'h01);
        step();
        step();
        chk("blank_wrap_dsel", 8'(digit_sel), 8'h00);
        chk("blank_wrap_seg", 8'(seg), 8'h71);

        // Boundary load: pending becomes visible one edge after the accept.
        sync_phase(18);
        chk("bl_ready", 8'(data_ready), 8'h01);
        data_in = 8'h3C; data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        chk("bl_ready_low", 8'(data_ready), 8'h00);
        chk("bl_shown_old", shown, 8'hFF);
        step();
        chk("bl_shown_new", shown, 8'h3C);
        chk("bl_ready_back", 8'(data_ready), 8'h01);
        chk("bl_seg_lo", 8'(seg), 8'h39);

        // Reset mid-SHOW_HI with a byte pending.
        step();
        data_in = 8'h5A; data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        chk("rm_ready_low", 8'(data_ready), 8'h00);
        sync_phase(14);
        chk("rm_pre_shown", shown, 8'h3C);
        do_reset();
        chk("rm_shown", shown, 8'h00);
        chk("rm_ready", 8'(data_ready), 8'h01);
        chk("rm_seg", 8'(seg), 8'h3F);
        chk("rm_dsel", 8'(digit_sel), 8'h00);
        frame_check("rm_frame", 7'h3F, hi_zero);
        chk("rm_pend_gone", shown, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
